// File: rtl/gc_poll_scheduler.sv
// Round-robin poll scheduler for the four GameCube controller ports with per-port presence tracking.
// Optional build macro GC_SKIP_ABSENT_EN: absent ports are polled only once every SKIP_ROUNDS rounds.
module gc_poll_scheduler #(
    parameter int unsigned SLOT_CYCLES    = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned MISS_LIMIT     = 3,
    parameter int unsigned SKIP_ROUNDS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] port_en,
    input  logic [3:0] done,
    output logic [3:0] start,
    output logic [3:0] present,
    output logic [1:0] active_port,
    output logic       frame_tick
);

    localparam logic [12:0] SLOT_LAST = 13'(SLOT_CYCLES - 1);
    localparam logic [12:0] TO_LAST   = 13'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  MISS_MAX  = 4'(MISS_LIMIT);

    if (SLOT_CYCLES < 3 || SLOT_CYCLES > 8192) begin : g_bad_slot
        $error("SLOT_CYCLES must be in 3..8192");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= SLOT_CYCLES) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2 and < SLOT_CYCLES");
    end
    if (MISS_LIMIT < 1 || MISS_LIMIT > 15) begin : g_bad_miss
        $error("MISS_LIMIT must be in 1..15");
    end
    if (SKIP_ROUNDS < 1 || SKIP_ROUNDS > 8192) begin : g_bad_skip
        $error("SKIP_ROUNDS must be in 1..8192");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [12:0] cnt_q;
    logic [3:0]  start_q;
    logic [3:0]  present_q;
    logic        frame_q;
    logic        drop_q;
    logic [3:0]  miss_q [4];

`ifdef GC_SKIP_ABSENT_EN
    localparam logic [12:0] ROUND_LAST = 13'(SKIP_ROUNDS - 1);
    logic [12:0] round_q;
`endif

    logic [3:0] elig;
    logic       sel_found;
    logic [1:0] sel_idx;
    logic [1:0] cand;
    logic       res_hit;
    logic       res_miss;
    logic       res_keep;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < 4; i++) begin
`ifdef GC_SKIP_ABSENT_EN
            elig[i] = port_en[i] &&
                      (present_q[i] || (miss_q[i] != MISS_MAX) || (round_q == '0));
`else
            elig[i] = port_en[i];
`endif
        end
    end

    // Search order ptr+1, ptr+2, ptr+3, ptr: the 2-bit add wraps naturally.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign res_hit  = (state_q == S_WAIT) && done[ptr_q];
    assign res_miss = (state_q == S_WAIT) && !done[ptr_q] && (cnt_q == TO_LAST);
    // A slot whose port was disabled at any point before the decision is discarded.
    assign res_keep = port_en[ptr_q] && !drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd3;
            cnt_q     <= '0;
            start_q   <= '0;
            present_q <= '0;
            frame_q   <= 1'b0;
            drop_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                miss_q[i] <= '0;
            end
`ifdef GC_SKIP_ABSENT_EN
            round_q   <= '0;
`endif
        end else begin
            start_q <= '0;
            frame_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (port_en != '0) begin
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (sel_found) begin
                        state_q <= S_START;
                        ptr_q   <= sel_idx;
                        start_q <= 4'b0001 << sel_idx;
                        frame_q <= (sel_idx <= ptr_q);
                        cnt_q   <= '0;
                        drop_q  <= 1'b0;
`ifdef GC_SKIP_ABSENT_EN
                        if (sel_idx <= ptr_q) begin
                            round_q <= (round_q == ROUND_LAST) ? '0 : round_q + 13'd1;
                        end
`endif
                    end else begin
                        state_q <= S_IDLE;
`ifdef GC_SKIP_ABSENT_EN
                        // Enabled but all skipped: count this as a round so absent ports get retried.
                        if (port_en != '0) begin
                            round_q <= (round_q == ROUND_LAST) ? '0 : round_q + 13'd1;
                        end
`endif
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                    cnt_q   <= cnt_q + 13'd1;
                    drop_q  <= drop_q | !port_en[ptr_q];
                end
                S_WAIT: begin
                    cnt_q  <= cnt_q + 13'd1;
                    drop_q <= drop_q | !port_en[ptr_q];
                    if (done[ptr_q] || (cnt_q == TO_LAST)) begin
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_q <= S_SELECT;
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            for (int unsigned i = 0; i < 4; i++) begin
                if (!port_en[i]) begin
                    present_q[i] <= 1'b0;
                    miss_q[i]    <= '0;
                end else if ((2'(i) == ptr_q) && res_keep) begin
                    if (res_hit) begin
                        present_q[i] <= 1'b1;
                        miss_q[i]    <= '0;
                    end else if (res_miss) begin
                        if (miss_q[i] != MISS_MAX) begin
                            miss_q[i] <= miss_q[i] + 4'd1;
                        end
                        if (miss_q[i] >= MISS_MAX - 4'd1) begin
                            present_q[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign start       = start_q;
    assign present     = present_q;
    assign active_port = ptr_q;
    assign frame_tick  = frame_q;

endmodule

// File: doc/gc_poll_scheduler.md
# gc_poll_scheduler

Sequences polling of the four GameCube controller ports so that only one port starts a poll at a time. Ports are served round-robin in fixed-length slots. The block issues a one-cycle start strobe to the selected port's poll generator and waits for a valid-response strobe or a timeout. It keeps a per-port presence flag for the N64-side control logic. It sits between the top-level clock/enable domain and the four per-port poll generator / response capture pairs.

## Interface
- SLOT_CYCLES, 6000, cycles from a port's start strobe to the next SELECT; 500 µs at 12 MHz.
- TIMEOUT_CYCLES, 5000, cycles after start within which done must arrive; must be < SLOT_CYCLES.
- MISS_LIMIT, 3, consecutive misses that clear present; range 1–15.
- SKIP_ROUNDS, 8, round divider for absent ports; only used with GC_SKIP_ABSENT_EN; ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- port_en  in  4  per-port poll enable.
- done  in  4  one-cycle pulse: port i captured a valid response.
- start  out  4  one-hot one-cycle pulse: port i begins a poll.
- present  out  4  port i has a responding controller.
- active_port  out  2  index of the port owning the current slot.
- frame_tick  out  1  one-cycle pulse at the end of a round.

## Operation
- FSM states: IDLE, SELECT, START, WAIT, GAP.
- IDLE: go to SELECT when port_en != 0.
- SELECT (1 cycle): choose the first eligible port in the order ptr+1, ptr+2, ptr+3, ptr, mod 4.
  - A port is eligible when its port_en bit is set (and, with the macro, it passes the skip rule).
  - If no port is eligible, go to IDLE.
  - Load ptr and active_port with the chosen port.
  - Pulse frame_tick when the new index ≤ the previous index, i.e. the order wrapped. It also pulses on the very first selection after reset.
- START (1 cycle): start[ptr]=1 and slot counter cleared to 0. Then go to WAIT.
- WAIT: slot counter increments every cycle.
  - done[ptr]=1 → hit, go to GAP.
  - Counter reaching TIMEOUT_CYCLES-1 with no done → miss, go to GAP.
  - If done and timeout occur in the same cycle, done wins (hit).
- GAP: the counter keeps running. When it reaches SLOT_CYCLES-1, go to SELECT.
- done bits for any port other than ptr, and done outside WAIT, are ignored.
- Presence update, per port:
  - Hit: present=1 and miss_cnt=0.
  - Miss: miss_cnt increments, saturating at MISS_LIMIT. When it reaches MISS_LIMIT, present=0.
- port_en[i] falling clears present[i] and miss_cnt[i] on the next cycle. If i is the active port, the slot runs to completion but its result is discarded.
- Counters are 13 bits wide; parameters are checked at elaboration so they fit.

## Timing
- Reset values: state=IDLE, ptr=3 (so port 0 is selected first), start=0, present=0, active_port=3, frame_tick=0, all miss_cnt=0, slot counter=0.
- The first start is issued 2 cycles after leaving IDLE: SELECT, then START.
- Start-to-start spacing is SLOT_CYCLES+1 cycles whenever at least one port stays eligible. With only one port enabled, that same port is re-polled at this spacing.
- present updates on the cycle after the hit or miss decision.
- Reset asserted mid-slot returns everything to reset values on the next edge. No start pulse is emitted during reset.

## Configuration
- GC_SKIP_ABSENT_EN defined:
  - A round counter increments on each frame_tick and wraps at SKIP_ROUNDS.
  - A port with present=0 and miss_cnt=MISS_LIMIT is eligible only when the round counter equals 0. Present ports are always eligible.
  - This reduces bus traffic on empty ports.
- GC_SKIP_ABSENT_EN undefined: every enabled port is eligible every round, and the round counter is not built.

## Test plan
- Reset, then port_en=4'b1111 with done returned 100 cycles after each start → start pulses on ports 0,1,2,3,0… spaced 6001 cycles. present becomes 4'b1111 after the first round. frame_tick fires on each selection of port 0.
- port_en=4'b0101 → starts alternate 0,2,0,2. Ports 1 and 3 never see start; present[1] and present[3] stay 0.
- Port 2 stops returning done → after 3 slots of port 2, present[2]=0. A single later done restores present[2]=1 and miss_cnt=0.
- done[ptr] on exactly cycle TIMEOUT_CYCLES-1 → counted as a hit. done[1] pulsed during port 0's WAIT → ignored, and port 0 still times out.
- Deassert rst_n mid-WAIT on port 1 → all outputs return to reset values the next cycle. After release, the next start goes to port 0.
- With GC_SKIP_ABSENT_EN, port 3 absent and SKIP_ROUNDS=8 → port 3 receives start once per 8 frame_ticks while ports 0–2 are polled every round.
